// File: rtl/icff_pkg.sv
// Shared helpers and constants for the parametrised single-clock FIFO.
// Parameter legality functions are evaluated at elaboration by the top level.
package icff_pkg;

    localparam logic [63:0] RST_DO = '0;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    function automatic bit depth_ok(input int depth);
        return (depth >= 4) && (depth <= 4096) && ((depth & (depth - 1)) == 0);
    endfunction

    function automatic bit levels_ok(input int ae_lvl, input int af_lvl, input int depth);
        return (ae_lvl < af_lvl) && (af_lvl < depth);
    endfunction

    function automatic bit width_ok(input int dw);
        return (dw >= 1) && (dw <= 64);
    endfunction

endpackage

// File: rtl/icff_fifo_ram.sv
// Simple dual-port storage: one synchronous write port, one read port that is
// either combinational (FWFT) or registered with a read enable.
module icff_fifo_ram
    import icff_pkg::*;
#(
    parameter int DW    = 16,
    parameter int DEPTH = 512,
    parameter int AW    = 9,
    parameter int FWFT  = 0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          srst_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic          re_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end

    if (FWFT != 0) begin : g_comb_rd
        logic unused_ctrl;
        assign unused_ctrl = ^{rst_n, srst_i, re_i};
        assign rdata_o     = mem_q[raddr_i];
    end else begin : g_reg_rd
        logic [DW-1:0] rdata_q;

        // flush clears the output register as well as the pointers
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)      rdata_q <= RST_DO[DW-1:0];
            else if (srst_i) rdata_q <= RST_DO[DW-1:0];
            else if (re_i)   rdata_q <= mem_q[raddr_i];
        end

        assign rdata_o = rdata_q;
    end

endmodule

// File: rtl/icff_fifo_gen.sv
// Parametrised synchronous FIFO: pointers, occupancy count, level flags and
// sticky overflow/underflow errors around the icff_fifo_ram storage.
module icff_fifo_gen
    import icff_pkg::*;
#(
    parameter int  DW     = 16,
    parameter int  DEPTH  = 512,
    parameter int  AE_LVL = 6,
    parameter int  AF_LVL = 506,
    parameter int  FWFT   = 0,
    localparam int AW     = clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          srst,
    input  logic          we,
    input  logic [DW-1:0] di,
    input  logic          re,
    input  logic          clr_err,
    output logic [DW-1:0] do_o,
    output logic          empty_flag,
    output logic          full_flag,
    output logic          almost_empty,
    output logic          almost_full,
    output logic [AW:0]   count,
    output logic          ovf,
    output logic          udf
);

    if (!depth_ok(DEPTH)) begin : g_bad_depth
        $error("icff_fifo_gen: DEPTH must be a power of two in 4..4096");
    end
    if (!levels_ok(AE_LVL, AF_LVL, DEPTH)) begin : g_bad_levels
        $error("icff_fifo_gen: levels must satisfy AE_LVL < AF_LVL < DEPTH");
    end
    if (!width_ok(DW)) begin : g_bad_width
        $error("icff_fifo_gen: DW must be in 1..64");
    end

    logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [AW:0]   count_q, count_d;
    logic          ovf_q, ovf_d, udf_q, udf_d;
    logic          wr_ok, rd_ok;
    logic [DW-1:0] rdata;

    assign empty_flag   = (count_q == '0);
    assign full_flag    = (count_q == (AW+1)'(DEPTH));
    assign almost_empty = (count_q <= (AW+1)'(AE_LVL));
    assign almost_full  = (count_q >= (AW+1)'(AF_LVL));
    assign count        = count_q;
    assign ovf          = ovf_q;
    assign udf          = udf_q;

    // flush masks both requests so nothing is stored or consumed that cycle
    assign wr_ok = we & ~full_flag & ~srst;
    assign rd_ok = re & ~empty_flag & ~srst;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        udf_d   = udf_q;
        if (srst) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            if (wr_ok) wptr_d = wptr_q + AW'(1);
            if (rd_ok) rptr_d = rptr_q + AW'(1);
            case ({wr_ok, rd_ok})
                2'b10:   count_d = count_q + (AW+1)'(1);
                2'b01:   count_d = count_q - (AW+1)'(1);
                default: count_d = count_q;
            endcase
            // set takes precedence over a coincident clear
            ovf_d = (ovf_q & ~clr_err) | (we & full_flag);
            udf_d = (udf_q & ~clr_err) | (re & empty_flag);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
        end
    end

    icff_fifo_ram #(
        .DW    (DW),
        .DEPTH (DEPTH),
        .AW    (AW),
        .FWFT  (FWFT)
    ) u_ram (
        .clk     (clk),
        .rst_n   (rst_n),
        .srst_i  (srst),
        .we_i    (wr_ok),
        .waddr_i (wptr_q),
        .wdata_i (di),
        .re_i    (rd_ok),
        .raddr_i (rptr_q),
        .rdata_o (rdata)
    );

    if (FWFT != 0) begin : g_fwft_out
        assign do_o = empty_flag ? RST_DO[DW-1:0] : rdata;
    end else begin : g_std_out
        assign do_o = rdata;
    end

endmodule

// File: tb/tb_icff_fifo_gen.sv
// Directed bench for icff_fifo_gen: one standard-read and one FWFT instance,
// DW=16, DEPTH=16, AE_LVL=2, AF_LVL=14, checked with immediate assertions.
module tb_icff_fifo_gen;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    int          n_cmp = 0;
    int          n_bad = 0;

    logic        srst0 = 0, we0 = 0, re0 = 0, clr0 = 0;
    logic [15:0] di0 = '0, do0;
    logic        emp0, ful0, ae0, af0, ovf0, udf0;
    logic [4:0]  cnt0;

    logic        srst1 = 0, we1 = 0, re1 = 0, clr1 = 0;
    logic [15:0] di1 = '0, do1;
    logic        emp1, ful1, ae1, af1, ovf1, udf1;
    logic [4:0]  cnt1;

    always #5 clk = ~clk;

    icff_fifo_gen #(.DW(16), .DEPTH(16), .AE_LVL(2), .AF_LVL(14), .FWFT(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .srst(srst0), .we(we0), .di(di0), .re(re0),
        .clr_err(clr0), .do_o(do0), .empty_flag(emp0), .full_flag(ful0),
        .almost_empty(ae0), .almost_full(af0), .count(cnt0), .ovf(ovf0), .udf(udf0)
    );

    icff_fifo_gen #(.DW(16), .DEPTH(16), .AE_LVL(2), .AF_LVL(14), .FWFT(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .srst(srst1), .we(we1), .di(di1), .re(re1),
        .clr_err(clr1), .do_o(do1), .empty_flag(emp1), .full_flag(ful1),
        .almost_empty(ae1), .almost_full(af1), .count(cnt1), .ovf(ovf1), .udf(udf1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // reset then idle
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        chk("rst_empty", emp0, 1);
        chk("rst_ae", ae0, 1);
        chk("rst_full", ful0, 0);
        chk("rst_af", af0, 0);
        chk("rst_count", cnt0, 0);
        chk("rst_do", do0, 16'h0000);
        chk("rst_ovf", ovf0, 0);
        chk("rst_udf", udf0, 0);

        // fill to full
        for (int i = 0; i < 16; i++) begin
            we0 = 1; di0 = 16'h1000 + 16'(i);
            tick();
            chk("fill_count", cnt0, 32'(i + 1));
            if (i == 1)  chk("fill_ae_at2", ae0, 1);
            if (i == 2)  chk("fill_ae_at3", ae0, 0);
            if (i == 12) chk("fill_af_at13", af0, 0);
            if (i == 13) chk("fill_af_at14", af0, 1);
            if (i == 14) chk("fill_full_at15", ful0, 0);
        end
        chk("fill_full", ful0, 1);
        chk("fill_count16", cnt0, 16);
        di0 = 16'hFFFF;
        tick();
        we0 = 0;
        chk("ovf_17th", ovf0, 1);
        chk("ovf_count", cnt0, 16);
        clr0 = 1;
        tick();
        clr0 = 0;
        chk("clr_ovf", ovf0, 0);

        // drain with 1-clock read latency
        for (int i = 0; i < 16; i++) begin
            re0 = 1;
            tick();
            chk("drain_do", do0, 32'(16'h1000 + 16'(i)));
            chk("drain_count", cnt0, 32'(15 - i));
        end
        re0 = 0;
        tick();
        chk("do_hold", do0, 16'h100F);
        chk("drain_empty", emp0, 1);
        re0 = 1;
        tick();
        re0 = 0;
        chk("udf_set", udf0, 1);
        chk("udf_do_hold", do0, 16'h100F);
        chk("udf_count", cnt0, 0);
        clr0 = 1;
        tick();
        clr0 = 0;
        chk("clr_udf", udf0, 0);

        // simultaneous read/write at count=8 across pointer wrap
        for (int i = 0; i < 8; i++) begin
            we0 = 1; di0 = 16'h2000 + 16'(i);
            tick();
        end
        for (int k = 0; k < 10; k++) begin
            we0 = 1; re0 = 1; di0 = 16'h2008 + 16'(k);
            tick();
            chk("rw_do", do0, 32'(16'h2000 + 16'(k)));
            chk("rw_count", cnt0, 8);
        end
        we0 = 0;
        for (int i = 0; i < 8; i++) begin
            re0 = 1;
            tick();
            chk("wrap_do", do0, 32'(16'h200A + 16'(i)));
        end
        re0 = 0;
        chk("wrap_empty", emp0, 1);

        // full plus we & re
        for (int i = 0; i < 16; i++) begin
            we0 = 1; di0 = 16'h3000 + 16'(i);
            tick();
        end
        we0 = 1; re0 = 1; di0 = 16'hDEAD;
        tick();
        we0 = 0; re0 = 0;
        chk("full_rw_count", cnt0, 15);
        chk("full_rw_ovf", ovf0, 1);
        chk("full_rw_do", do0, 16'h3000);
        for (int i = 0; i < 6; i++) begin
            re0 = 1;
            tick();
        end
        re0 = 0;
        chk("pre_srst_count", cnt0, 9);
        chk("pre_srst_do", do0, 16'h3006);

        // flush with a concurrent write
        we0 = 1; srst0 = 1; di0 = 16'h7777;
        tick();
        we0 = 0; srst0 = 0;
        chk("srst_count", cnt0, 0);
        chk("srst_empty", emp0, 1);
        chk("srst_ovf", ovf0, 1);
        chk("srst_do", do0, 16'h0000);
        clr0 = 1;
        tick();
        clr0 = 0;
        chk("clr_ovf2", ovf0, 0);

        // clear coincident with a new overflow
        for (int i = 0; i < 16; i++) begin
            we0 = 1; di0 = 16'h4000 + 16'(i);
            tick();
        end
        we0 = 1; clr0 = 1;
        tick();
        we0 = 0; clr0 = 0;
        chk("clr_vs_ovf", ovf0, 1);
        chk("clr_vs_ovf_cnt", cnt0, 16);

        // empty plus we & re
        srst0 = 1;
        tick();
        srst0 = 0;
        we0 = 1; re0 = 1; di0 = 16'h5555;
        tick();
        we0 = 0; re0 = 0;
        chk("empty_rw_count", cnt0, 1);
        chk("empty_rw_udf", udf0, 1);
        chk("empty_rw_do", do0, 16'h0000);
        re0 = 1;
        tick();
        re0 = 0;
        chk("empty_rw_read", do0, 16'h5555);

        // async reset between edges at count=5
        for (int i = 0; i < 5; i++) begin
            we0 = 1; di0 = 16'h6000 + 16'(i);
            tick();
        end
        we0 = 0;
        chk("pre_arst_count", cnt0, 5);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_count", cnt0, 0);
        chk("arst_empty", emp0, 1);
        chk("arst_ae", ae0, 1);
        chk("arst_full", ful0, 0);
        chk("arst_do", do0, 16'h0000);
        chk("arst_ovf", ovf0, 0);
        chk("arst_udf", udf0, 0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("post_arst_empty", emp0, 1);

        // first-word-fall-through instance
        chk("fwft_idle_do", do1, 16'h0000);
        chk("fwft_idle_empty", emp1, 1);
        we1 = 1; di1 = 16'hBEEF;
        tick();
        we1 = 0;
        chk("fwft_first_do", do1, 16'hBEEF);
        chk("fwft_not_empty", emp1, 0);
        re1 = 1;
        tick();
        re1 = 0;
        chk("fwft_rd_empty", emp1, 1);
        chk("fwft_rd_do", do1, 16'h0000);
        we1 = 1; di1 = 16'h00A1;
        tick();
        di1 = 16'h00A2;
        tick();
        we1 = 0;
        chk("fwft_head", do1, 16'h00A1);
        chk("fwft_count2", cnt1, 2);
        re1 = 1;
        tick();
        chk("fwft_advance", do1, 16'h00A2);
        chk("fwft_count1", cnt1, 1);
        tick();
        re1 = 0;
        chk("fwft_drained", emp1, 1);
        chk("fwft_drained_do", do1, 16'h0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/icff_fifo_gen.md
Name: icff_fifo_gen

Overview:
- Parametrised single-clock synchronous FIFO in portable RTL; the next generation of the fixed 16-bit, 512-entry vendor-primitive FIFO wrapper.
- Generalised in data width, depth, almost-empty/almost-full levels and read mode (standard or first-word-fall-through).
- Adds behaviour the vendor wrapper lacks:
  - occupancy count output;
  - sticky overflow/underflow error flags with clear;
  - synchronous flush.
- Used as the interconnect buffer between bus masters and peripherals.

Parameters:
- DW, 16, data width in bits (1..64).
- DEPTH, 512, number of entries; power of two, 4..4096.
- AE_LVL, 6, almost_empty asserts when count <= AE_LVL.
- AF_LVL, 506, almost_full asserts when count >= AF_LVL; must satisfy AE_LVL < AF_LVL < DEPTH.
- FWFT, 0, 0 = standard (registered) read, 1 = first-word-fall-through.

Ports:
- clk  in  1  sole clock; all logic updates on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- srst  in  1  synchronous flush; active-high; one cycle.
- we  in  1  write request.
- di  in  DW  write data.
- re  in  1  read request.
- clr_err  in  1  clears the sticky error flags; one-cycle pulse.
- do  out  DW  read data.
- empty_flag  out  1  count == 0.
- full_flag  out  1  count == DEPTH.
- almost_empty  out  1  count <= AE_LVL.
- almost_full  out  1  count >= AF_LVL.
- count  out  AW+1  occupancy 0..DEPTH, where AW = clog2(DEPTH).
- ovf  out  1  sticky: a write was rejected.
- udf  out  1  sticky: a read was rejected.

Behaviour:
- Reset (rst_n low, asynchronous), all outputs:
  - count = 0, wptr = rptr = 0, do = 0, ovf = udf = 0;
  - empty_flag = 1, almost_empty = 1, full_flag = 0, almost_full = 0.
  - Memory contents are not reset.
- Accept rules, evaluated on registered state at the edge:
  - wr_ok = we & ~full_flag.
  - rd_ok = re & ~empty_flag.
  - Write and read are independent; both may be accepted in the same cycle.
- Pointers:
  - AW bits each, wrap naturally from DEPTH-1 to 0.
  - wr_ok: mem[wptr] <= di, wptr++.
  - rd_ok: rptr++.
- count:
  - +1 on wr_ok only; -1 on rd_ok only; unchanged if both or neither.
  - All flags are decoded from registered count, so they change on the edge after the accepting edge.
- Full and simultaneous we & re: the read is accepted and the write is rejected (ovf <= 1). count becomes DEPTH-1.
- Empty and simultaneous we & re: the write is accepted and the read is rejected (udf <= 1). count becomes 1.
- Errors:
  - ovf <= 1 on we & full_flag; udf <= 1 on re & empty_flag.
  - Both are held until clr_err. clr_err in the same cycle as a new error leaves the flag set (set wins).
- FWFT = 0:
  - On rd_ok, do <= mem[rptr]; data is valid on the cycle after the read edge.
  - do holds its value when no read is accepted.
  - Read latency is 1 clock.
- FWFT = 1:
  - do = mem[rptr] combinationally while ~empty_flag; do = 0 when empty.
  - The first word appears on the cycle after its write edge.
  - rd_ok advances to the next word with 0 latency.
  - Write-to-read bypass is not required; empty is based on registered count.
- srst (higher priority than we/re in the same cycle):
  - count, wptr, rptr <= 0; we/re in that cycle are ignored.
  - ovf/udf are unaffected; do <= 0.
- rst_n asserted mid-operation: immediate clear to the reset values above; state after release is empty.

Decomposition:
- Package icff_pkg:
  - function clog2;
  - localparam-style reset constants (RST_DO = 0);
  - parameter legality checks, issued as elaboration-time $error on a violated DEPTH or level rule.
- Sub-module icff_fifo_ram: simple dual-port array with one write port (clk, we, waddr, wdata) and one read port.
  - Read port is combinational (FWFT = 1) or registered with read enable (FWFT = 0), selected by parameter.
- Top level holds pointers, count, flags and error logic.

Test Plan (DW=16, DEPTH=16, AE_LVL=2, AF_LVL=14 unless noted):
- Reset then idle:
  - rst_n low for 3 clocks, then release -> empty_flag=1, almost_empty=1, count=0, do=16'h0000, ovf=udf=0.
- Fill to full:
  - 16 writes of 16'h1000+i -> after write 14, almost_full=1; after write 16, full_flag=1, count=16.
  - A 17th write -> ovf=1, count stays 16.
  - Drain 16 words with FWFT=0 -> do equals 16'h1000..16'h100F in order, each 1 clock after its read.
- Simultaneous we & re at count=8 for 10 cycles -> count stays 8; data order preserved across pointer wrap.
  - Full plus we & re -> count=15, ovf=1.
  - Empty plus we & re -> count=1, udf=1.
- FWFT=1:
  - Write 16'hBEEF into empty -> next cycle do=16'hBEEF and empty_flag=0.
  - Assert re -> empty_flag=1 on the following cycle, do=0.
- srst and clr_err:
  - At count=9 with we=1, srst=1 -> next cycle count=0, empty_flag=1, ovf unchanged.
  - clr_err with ovf=1 -> ovf=0.
  - clr_err together with a new overflow -> ovf=1.
- Async reset mid-burst: rst_n low between clock edges at count=5 -> outputs reach reset values before the next edge.
